conv3_streamer: RTL and testbench

CONV3_STREAMER -- requirements
Module: conv3_streamer

---
 rtl/conv3_streamer.sv | 149 ++++++++++++++
 tb/tb_conv3_streamer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/conv3_streamer.sv
// Frame streamer for a 3-wide convolver: replays a stored image one pixel per
// cycle with row/col tags and captures the convolver's results into a buffer.
module conv3_streamer #(
  parameter int ROWS  = 28,
  parameter int COLS  = 3,
  parameter int DRAIN = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        img_wr_en,
  input  logic [6:0]  img_wr_addr,
  input  logic [15:0] img_wr_data,
  output logic [15:0] data_in,
  output logic [4:0]  row,
  output logic [1:0]  col,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  input  logic [6:0]  res_rd_addr,
  output logic [31:0] res_rd_data,
  output logic [6:0]  res_count,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam int NPIX = ROWS * COLS;
  localparam int NRES = (ROWS - 2) * COLS;
  localparam int DW   = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t state_reg, state_next;

  logic [15:0] img_mem [NPIX];
  logic [31:0] res_mem [NRES];

  logic [6:0]    k_reg;
  logic [DW-1:0] drain_reg;
  logic [15:0]   data_in_reg;
  logic [4:0]    row_reg;
  logic [1:0]    col_reg;
  logic [6:0]    count_reg;
  logic          overflow_reg;
  logic [31:0]   rd_data_reg;

  logic       accept_start;
  logic       last_pix;
  logic       drain_end;
  logic       load_pix;
  logic       capturing;
  logic       res_full;
  logic [6:0] pix_addr;

  assign accept_start = (state_reg == S_IDLE) && start;
  assign last_pix     = (k_reg == 7'(NPIX - 1));
  assign drain_end    = (drain_reg == DW'(DRAIN - 1));
  assign capturing    = res_valid && ((state_reg == S_STREAM) || (state_reg == S_DRAIN));
  assign res_full     = (count_reg == 7'(NRES));

  // The pixel for the next cycle is fetched now so the output register
  // presents pixel 0 in the very first STREAM cycle.
  assign load_pix = accept_start || ((state_reg == S_STREAM) && !last_pix);
  assign pix_addr = (state_reg == S_STREAM) ? k_reg + 7'd1 : 7'd0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start)     state_next = S_STREAM;
      S_STREAM: if (last_pix)  state_next = S_DRAIN;
      S_DRAIN:  if (drain_end) state_next = S_DONE;
      S_DONE:                  state_next = S_IDLE;
      default:                 state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      k_reg        <= '0;
      drain_reg    <= '0;
      data_in_reg  <= '0;
      row_reg      <= '0;
      col_reg      <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      state_reg <= state_next;

      if (load_pix) begin
        data_in_reg <= img_mem[pix_addr];
        k_reg       <= pix_addr;
        if (accept_start) begin
          row_reg <= '0;
          col_reg <= '0;
        end else if (col_reg == 2'(COLS - 1)) begin
          row_reg <= row_reg + 5'd1;
          col_reg <= '0;
        end else begin
          col_reg <= col_reg + 2'd1;
        end
      end else begin
        data_in_reg <= '0;
        row_reg     <= '0;
        col_reg     <= '0;
      end

      if (state_reg == S_DRAIN)
        drain_reg <= drain_reg + 1'b1;
      else
        drain_reg <= '0;

      if (accept_start) begin
        count_reg    <= '0;
        overflow_reg <= 1'b0;
      end else if (capturing) begin
        if (res_full)
          overflow_reg <= 1'b1;
        else
          count_reg <= count_reg + 7'd1;
      end

      if (res_rd_addr < 7'(NRES))
        rd_data_reg <= res_mem[res_rd_addr];
      else
        rd_data_reg <= '0;
    end
  end

  // Buffer storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (img_wr_en && ((state_reg == S_IDLE) || (state_reg == S_DONE)) &&
        (img_wr_addr < 7'(NPIX)))
      img_mem[img_wr_addr] <= img_wr_data;
    if (capturing && !res_full)
      res_mem[count_reg] <= res_data;
  end

  assign data_in     = data_in_reg;
  assign row         = row_reg;
  assign col         = col_reg;
  assign res_count   = count_reg;
  assign overflow    = overflow_reg;
  assign res_rd_data = rd_data_reg;
  assign busy        = (state_reg == S_STREAM) || (state_reg == S_DRAIN);
  assign done        = (state_reg == S_DONE);

endmodule

// File: tb/tb_conv3_streamer.sv
// Bench for conv3_streamer: a frame-cycle model checked every cycle, plus
// directed frames with hand-computed literal expectations.
module tb_conv3_streamer;

  localparam int NPIX  = 84;
  localparam int NRES  = 78;
  localparam int T_END = 92;   // last busy cycle of a frame (84 stream + 8 drain)
  localparam int T_DN  = 93;   // cycle in which done is high

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        img_wr_en = 1'b0;
  logic [6:0]  img_wr_addr = '0;
  logic [15:0] img_wr_data = '0;
  logic [15:0] data_in;
  logic [4:0]  row;
  logic [1:0]  col;
  logic        res_valid = 1'b0;
  logic [31:0] res_data = '0;
  logic [6:0]  res_rd_addr = '0;
  logic [31:0] res_rd_data;
  logic [6:0]  res_count;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  conv3_streamer dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .img_wr_en(img_wr_en), .img_wr_addr(img_wr_addr), .img_wr_data(img_wr_data),
    .data_in(data_in), .row(row), .col(col),
    .res_valid(res_valid), .res_data(res_data),
    .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data),
    .res_count(res_count), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: m_t counts cycles since the accepted start edge (1 = first pixel).
  bit          m_act = 1'b0;
  int          m_t = 0;
  logic [15:0] img_m [NPIX];
  logic [31:0] res_m [NRES];
  bit          res_known [NRES];
  int          m_cnt = 0;
  bit          m_ovf = 1'b0;
  logic [31:0] m_rd = '0;
  bit          m_rd_known = 1'b1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_act = 1'b0; m_t = 0; m_cnt = 0; m_ovf = 1'b0; m_rd = '0; m_rd_known = 1'b1;
    end else begin
      if (int'(res_rd_addr) < NRES) begin
        m_rd = res_m[res_rd_addr]; m_rd_known = res_known[res_rd_addr];
      end else begin
        m_rd = '0; m_rd_known = 1'b1;
      end
      if ((!m_act || m_t == T_DN) && img_wr_en && int'(img_wr_addr) < NPIX)
        img_m[img_wr_addr] = img_wr_data;
      if (m_act && m_t <= T_END && res_valid) begin
        if (m_cnt < NRES) begin
          res_m[m_cnt] = res_data; res_known[m_cnt] = 1'b1; m_cnt++;
        end else m_ovf = 1'b1;
      end
      if (!m_act) begin
        if (start) begin m_act = 1'b1; m_t = 1; m_cnt = 0; m_ovf = 1'b0; end
      end else if (m_t == T_DN) begin
        m_act = 1'b0; m_t = 0;
      end else m_t++;
    end
  end

  always @(negedge clk) begin
    if (reset_n && cmp_en) begin
      if (m_act && m_t <= NPIX) begin
        check("data_in", 32'(data_in), 32'(img_m[m_t-1]));
        check("row", 32'(row), 32'((m_t - 1) / 3));
        check("col", 32'(col), 32'((m_t - 1) % 3));
      end else begin
        check("data_in_idle", 32'(data_in), 32'd0);
        check("rowcol_idle", {25'd0, row, col}, 32'd0);
      end
      check("busy", 32'(busy), 32'(m_act && m_t <= T_END));
      check("done", 32'(done), 32'(m_act && m_t == T_DN));
      check("res_count", 32'(res_count), 32'(m_cnt));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (m_rd_known) check("res_rd_data", res_rd_data, m_rd);
    end
  end

  task automatic load_image();
    for (int k = 0; k < NPIX; k++) begin
      img_wr_en = 1'b1; img_wr_addr = 7'(k); img_wr_data = 16'(k + 1);
      @(negedge clk);
    end
    img_wr_en = 1'b0;
  endtask

  // Called at a negedge; image is always k+1 when this runs.
  task automatic run_frame(input int nres, input logic [31:0] base,
                           input bit disturb, input int abort_at);
    start = 1'b1;
    for (int c = 1; c <= 94; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        check("first_pix", {11'd0, data_in, row, col}, {11'd0, 16'd1, 5'd0, 2'd0});
        check("start_clr", {24'd0, res_count, overflow}, 32'd0);
      end
      if (c == 4)  check("pix3", 32'(data_in), 32'd4);
      if (c == 84) check("last_pix", {11'd0, data_in, row, col}, {11'd0, 16'd84, 5'd27, 2'd2});
      if (c == 85) check("drain_start", {15'd0, data_in, busy}, 32'd1);
      if (c == 92) check("drain_end", {30'd0, busy, done}, 32'b10);
      if (c == 93) check("done_pulse", {30'd0, busy, done}, 32'b01);
      if (c == 94) check("done_low", {30'd0, busy, done}, 32'b00);
      res_valid = (c <= nres);
      res_data  = base + 32'(c - 1);
      if (disturb) begin
        start = (c == 10);
        img_wr_en = (c == 20); img_wr_addr = 7'd3; img_wr_data = 16'hDEAD;
      end
      if (c == abort_at) begin
        #2 reset_n = 1'b0;
        #1;
        check("abort_zero", {7'd0, data_in, row, col, res_count, res_rd_data[0]}, 32'd0);
        check("abort_flags", {29'd0, busy, done, overflow}, 32'd0);
        check("abort_rd", res_rd_data, 32'd0);
        res_valid = 1'b0; start = 1'b0; img_wr_en = 1'b0;
        return;
      end
    end
    res_valid = 1'b0; start = 1'b0; img_wr_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_out", {7'd0, data_in, row, col, res_count, 1'b0}, 32'd0);
    check("reset_flags", {29'd0, busy, done, overflow}, 32'd0);
    check("reset_rd", res_rd_data, 32'd0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    @(negedge clk);
    load_image();

    // 78 results, stray start and image write during the stream
    run_frame(78, 32'h100, 1'b1, 0);
    check("count78", 32'(res_count), 32'd78);
    check("no_ovf", 32'(overflow), 32'd0);
    res_rd_addr = 7'd5;
    @(negedge clk);
    check("rd_addr5", res_rd_data, 32'h105);

    // 80 results: two overflow, buffer[3] must still be 4
    run_frame(80, 32'h200, 1'b0, 0);
    check("count_full", 32'(res_count), 32'd78);
    check("ovf_set", 32'(overflow), 32'd1);
    res_rd_addr = 7'd77;
    @(negedge clk);
    check("rd_addr77", res_rd_data, 32'h24D);
    res_rd_addr = 7'd100;
    @(negedge clk);
    check("rd_oob", res_rd_data, 32'd0);

    // Abort at stream cycle 40
    run_frame(10, 32'h300, 1'b0, 40);
    repeat (2) @(negedge clk);
    check("in_reset_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    load_image();
    run_frame(0, 32'h0, 1'b0, 0);
    check("count_zero", 32'(res_count), 32'd0);

    // res_valid in IDLE and an out-of-range image write are ignored
    res_valid = 1'b1; res_data = 32'hCAFE;
    img_wr_en = 1'b1; img_wr_addr = 7'd84; img_wr_data = 16'hBEEF;
    repeat (3) @(negedge clk);
    res_valid = 1'b0; img_wr_en = 1'b0;
    check("idle_res_ignored", 32'(res_count), 32'd0);
    run_frame(5, 32'h400, 1'b0, 0);
    check("count5", 32'(res_count), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
